// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM port among NumReq requesters.
// Bursts are bounded to MaxBurst accepts; responses return to their owner two cycles after accept.
module bram_rr_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 1024,
  parameter int unsigned AddrWidth = $clog2(Depth + 1),
  parameter int unsigned MaxBurst  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_data_o,
  output logic [$clog2(NumReq)-1:0]     grant_idx_o,
  output logic                          bram_write_en_o,
  output logic [AddrWidth-1:0]          bram_addr_o,
  output logic [DataWidth-1:0]          bram_data_o,
  input  logic [DataWidth-1:0]          bram_data_i
);

  localparam int unsigned IdxWidth = $clog2(NumReq);
  localparam int unsigned CntWidth = $clog2(MaxBurst + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   owner_q, owner_d;
  logic [CntWidth-1:0]   burst_cnt_q, burst_cnt_d;
  logic                  write_en_q, write_en_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  tag1_vld_q, tag1_vld_d;
  logic [IdxWidth-1:0]   tag1_idx_q, tag1_idx_d;
  logic                  tag2_vld_q, tag2_vld_d;
  logic [IdxWidth-1:0]   tag2_idx_q, tag2_idx_d;

  logic                  keep_owner;
  logic                  grant_vld;
  logic [IdxWidth-1:0]   grant_idx;
  logic [IdxWidth-1:0]   cand;

  logic [AddrWidth-1:0]  addr_arr [NumReq];
  logic [DataWidth-1:0]  data_arr [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign addr_arr[i] = req_addr_i[i*AddrWidth +: AddrWidth];
    assign data_arr[i] = req_data_i[i*DataWidth +: DataWidth];
  end

  // (base + off) mod NumReq without a divider; off never exceeds NumReq.
  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] base,
                                                   input int unsigned off);
    logic [IdxWidth:0] sum;
    sum = {1'b0, base} + (IdxWidth+1)'(off);
    if (sum >= (IdxWidth+1)'(NumReq)) sum = sum - (IdxWidth+1)'(NumReq);
    return sum[IdxWidth-1:0];
  endfunction

  // Owner is searched last so it only continues past its burst when nobody else wants the port.
  always_comb begin
    keep_owner = (state_q == BURST) && req_valid_i[owner_q] &&
                 (burst_cnt_q < CntWidth'(MaxBurst));
    grant_vld  = keep_owner;
    grant_idx  = owner_q;
    cand       = '0;
    if (!keep_owner) begin
      for (int unsigned k = 1; k <= NumReq; k++) begin
        cand = next_idx(owner_q, k);
        if (!grant_vld && req_valid_i[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld && rst_n_i) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    write_en_d  = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    tag1_vld_d  = grant_vld;
    tag1_idx_d  = grant_vld ? grant_idx : tag1_idx_q;
    tag2_vld_d  = tag1_vld_q;
    tag2_idx_d  = tag1_idx_q;
    if (grant_vld) begin
      state_d     = BURST;
      owner_d     = grant_idx;
      burst_cnt_d = keep_owner ? burst_cnt_q + CntWidth'(1) : CntWidth'(1);
      write_en_d  = req_write_i[grant_idx];
      addr_d      = addr_arr[grant_idx];
      data_d      = data_arr[grant_idx];
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      owner_q     <= IdxWidth'(NumReq - 1);
      burst_cnt_q <= '0;
      write_en_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_idx_q  <= '0;
      tag2_vld_q  <= 1'b0;
      tag2_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      write_en_q  <= write_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_idx_q  <= tag1_idx_d;
      tag2_vld_q  <= tag2_vld_d;
      tag2_idx_q  <= tag2_idx_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (tag2_vld_q) rsp_valid_o[tag2_idx_q] = 1'b1;
  end

  assign rsp_data_o      = bram_data_i;
  assign grant_idx_o     = owner_q;
  assign bram_write_en_o = write_en_q;
  assign bram_addr_o     = addr_q;
  assign bram_data_o     = data_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Randomised bench for bram_rr_arbiter against a cycle-level model of the arbitration rules,
// a write-first BRAM and an in-order response scoreboard.
module tb_bram_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam int MB    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      grant_idx;
  logic            bram_we;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_wdata;
  logic [DW-1:0]   bram_q = '0;
  logic [DW-1:0]   mem [16] = '{default: '0};

  logic [N-1:0]    rr_ready, rr_rsp_valid;
  logic [DW-1:0]   rr_rsp_data;
  logic [1:0]      rr_grant;
  logic            rr_we;
  logic [AW-1:0]   rr_addr;
  logic [DW-1:0]   rr_wdata;
  logic [DW-1:0]   rr_bram_q = '0;

  bram_rr_arbiter #(.NumReq(N), .DataWidth(DW), .Depth(DEPTH), .MaxBurst(MB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .grant_idx_o(grant_idx),
    .bram_write_en_o(bram_we), .bram_addr_o(bram_addr), .bram_data_o(bram_wdata),
    .bram_data_i(bram_q));

  bram_rr_arbiter #(.NumReq(N), .DataWidth(DW), .Depth(DEPTH), .MaxBurst(1)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rr_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rr_rsp_valid), .rsp_data_o(rr_rsp_data), .grant_idx_o(rr_grant),
    .bram_write_en_o(rr_we), .bram_addr_o(rr_addr), .bram_data_o(rr_wdata),
    .bram_data_i(rr_bram_q));

  always #5 clk = ~clk;

  // Write-first BRAM with one-cycle registered read; the bench only uses addresses 0..15.
  always @(posedge clk) begin
    if (bram_we) begin
      mem[bram_addr[3:0]] <= bram_wdata;
      bram_q              <= bram_wdata;
    end else begin
      bram_q <= mem[bram_addr[3:0]];
    end
  end

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  int            checks = 0;
  int            passes = 0;
  int            cyc;
  int            m_owner;
  int            m_streak;
  bit            m_prev_acc;
  int            exp_grant;
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rd;
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  rsp_t          exp_q [$];

  task automatic model_reset();
    m_owner    = N - 1;
    m_streak   = 0;
    m_prev_acc = 0;
    cyc        = 0;
    exp_q.delete();
  endtask

  // Evaluated at the negative edge: who should win this cycle and which response is due.
  task automatic model_eval();
    exp_grant = -1;
    if (m_prev_acc && req_valid[m_owner] && m_streak < MB) begin
      exp_grant = m_owner;
    end else begin
      for (int k = 1; k <= N; k++)
        if (exp_grant < 0 && req_valid[(m_owner + k) % N]) exp_grant = (m_owner + k) % N;
    end
    exp_ready = '0;
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    exp_rv = '0;
    exp_rd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv[exp_q[0].idx] = 1'b1;
      exp_rd = exp_q[0].data;
    end
  endtask

  task automatic model_commit();
    rsp_t          e;
    logic [AW-1:0] a;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    if (exp_grant >= 0) begin
      a = req_addr[exp_grant*AW +: AW];
      if (req_write[exp_grant]) ref_mem[a[3:0]] = req_data[exp_grant*DW +: DW];
      e.due  = cyc + 2;
      e.idx  = exp_grant;
      e.data = ref_mem[a[3:0]];
      exp_q.push_back(e);
      m_streak   = (m_prev_acc && exp_grant == m_owner && m_streak < MB) ? m_streak + 1 : 1;
      m_owner    = exp_grant;
      m_prev_acc = 1;
    end else begin
      m_prev_acc = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic new_cmd(input int i);
    req_write[i]          = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
    req_data[i*DW +: DW]  = DW'($urandom);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (grant_idx !== 2'(N - 1) || bram_we !== 1'b0 || rsp_valid !== '0 || bram_addr !== '0)
      $display("FAIL reset_state got owner=%0d we=%b rv=%b addr=%0d exp owner=%0d we=0 rv=0 addr=0",
               grant_idx, bram_we, rsp_valid, bram_addr, N - 1);
    else passes++;
    @(posedge clk);
    #1;
    cyc++;
    req_valid = 4'b0101;
    new_cmd(0);
    new_cmd(2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (req_ready !== exp_ready) $display("FAIL reset_pre_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      else passes++;
      model_commit();
      if (exp_grant >= 0) new_cmd(exp_grant);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) $display("FAIL reset_ready_low got=%b exp=0000", req_ready);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || bram_we !== 1'b0 || req_ready !== '0)
        $display("FAIL reset_hold k=%0d got rv=%b we=%b rdy=%b exp rv=0000 we=0 rdy=0000",
                 k, rsp_valid, bram_we, req_ready);
      else passes++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (rsp_valid !== exp_rv || req_ready !== exp_ready)
        $display("FAIL reset_no_late_rsp k=%0d got rv=%b rdy=%b exp rv=%b rdy=%b",
                 k, rsp_valid, req_ready, exp_rv, exp_ready);
      else passes++;
      model_commit();
    end
  endtask

  task automatic test_single();
    logic [N-1:0] one = 4'b0010;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      req_valid = (k < 2) ? one : '0;
      req_write[1]        = (k == 0);
      req_addr[1*AW +: AW] = AW'(7);
      req_data[1*DW +: DW] = (k == 0) ? 8'hA5 : 8'h3C;
      @(negedge clk);
      model_eval();
      checks++;
      if (req_ready !== exp_ready) $display("FAIL single_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      else passes++;
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_data !== exp_rd))
        $display("FAIL single_rsp k=%0d got rv=%b d=%h exp rv=%b d=%h", k, rsp_valid, rsp_data, exp_rv, exp_rd);
      else passes++;
      if (k == 2 || k == 3) begin
        checks++;
        if (rsp_valid !== one || rsp_data !== 8'hA5)
          $display("FAIL single_a5 k=%0d got rv=%b d=%h exp rv=0010 d=a5", k, rsp_valid, rsp_data);
        else passes++;
      end
      model_commit();
    end
  endtask

  task automatic test_burst_bound();
    logic [N-1:0] want;
    apply_reset();
    req_valid = 4'b0101;
    new_cmd(0);
    new_cmd(2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      model_eval();
      want = ((k / MB) % 2 == 1) ? 4'b0100 : 4'b0001;
      checks++;
      if (req_ready !== want) $display("FAIL burst_pattern k=%0d got=%b exp=%b", k, req_ready, want);
      else passes++;
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_data !== exp_rd))
        $display("FAIL burst_rsp k=%0d got rv=%b d=%h exp rv=%b d=%h", k, rsp_valid, rsp_data, exp_rv, exp_rd);
      else passes++;
      model_commit();
      if (exp_grant >= 0) new_cmd(exp_grant);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] want;
    apply_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) new_cmd(i);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      model_eval();
      want = '0;
      want[k % N] = 1'b1;
      checks++;
      if (rr_ready !== want) $display("FAIL rotation_mb1 k=%0d got=%b exp=%b", k, rr_ready, want);
      else passes++;
      checks++;
      if (req_ready !== exp_ready) $display("FAIL rotation_mb4 k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      else passes++;
      model_commit();
    end
  endtask

  task automatic test_early_release();
    logic [N-1:0] vseq [7] = '{4'b1000, 4'b1010, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    logic [N-1:0] rseq [7] = '{4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    apply_reset();
    new_cmd(1);
    new_cmd(3);
    for (int k = 0; k < 7; k++) begin
      req_valid = vseq[k];
      @(negedge clk);
      model_eval();
      checks++;
      if (req_ready !== rseq[k]) $display("FAIL early_release k=%0d got=%b exp=%b", k, req_ready, rseq[k]);
      else passes++;
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_data !== exp_rd))
        $display("FAIL early_rsp k=%0d got rv=%b d=%h exp rv=%b d=%h", k, rsp_valid, rsp_data, exp_rv, exp_rd);
      else passes++;
      model_commit();
      if (exp_grant >= 0) new_cmd(exp_grant);
    end
  endtask

  task automatic test_solo_regrant();
    apply_reset();
    new_cmd(2);
    for (int k = 0; k < 13; k++) begin
      req_valid = (k < 10) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      model_eval();
      checks++;
      if (req_ready !== ((k < 10) ? 4'b0100 : 4'b0000))
        $display("FAIL solo_ready k=%0d got=%b exp=%b", k, req_ready, (k < 10) ? 4'b0100 : 4'b0000);
      else passes++;
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_data !== exp_rd))
        $display("FAIL solo_rsp k=%0d got rv=%b d=%h exp rv=%b d=%h", k, rsp_valid, rsp_data, exp_rv, exp_rd);
      else passes++;
      model_commit();
      if (exp_grant >= 0) new_cmd(exp_grant);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (req_ready !== exp_ready) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      else passes++;
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv != '0 && rsp_data !== exp_rd))
        $display("FAIL rand_rsp cyc=%0d got rv=%b d=%h exp rv=%b d=%h", cyc, rsp_valid, rsp_data, exp_rv, exp_rd);
      else passes++;
      checks++;
      if (grant_idx !== 2'(m_owner)) $display("FAIL rand_owner cyc=%0d got=%0d exp=%0d", cyc, grant_idx, m_owner);
      else passes++;
      model_commit();
      for (int i = 0; i < N; i++) begin
        if (k >= 396) begin
          req_valid[i] = 1'b0;
        end else if (i == exp_grant || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          new_cmd(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_bound();
    test_rotation();
    test_early_release();
    test_solo_regrant();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
